mul_iter_mantissa: RTL and testbench
====================================

Name: mul_iter_mantissa

Overview:
- Upstream stage of the FP16 multiplier path: takes two FP16 operands and iteratively forms the 11x11-bit significand product with a shift-add datapath.
- Also forms the biased exponent sum and the result sign.
- Presents {sign, exponent[4:0], mantissa_prod[21:0]} with a valid/ready handshake; mul_normalizer consumes exponent and mantissa_prod directly.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration; legal values 1 or 2. Iteration count is 11 or 6 respectively.
- EXP_BIAS, 15, FP16 exponent bias subtracted from the exponent sum.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands (high only in IDLE).
- op_a  input  16  FP16 operand A, fields {s[15], e[14:10], f[9:0]}.
- op_b  input  16  FP16 operand B.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- sign  output  1  op_a[15] XOR op_b[15].
- exponent  output  5  low 5 bits of e_a + e_b - EXP_BIAS.
- mantissa_prod  output  22  unsigned product of the two 11-bit significands.

Behaviour:
- Reset: state=IDLE; in_ready=1 in the first cycle after reset; out_valid, sign, exponent, mantissa_prod, accumulator and counter all 0.
- Reset asserted mid-operation aborts the operation. The partial result is discarded, with no out_valid pulse.
- Significand: hidden bit = 1 when the exponent field is non-zero, else 0. Subnormals are treated as 0.f; there is no special NaN/Inf handling.
- FSM IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch multiplicand={hid_a, f_a}, multiplier={hid_b, f_b}, sign, and e_sum.
  - e_sum is a 7-bit signed value: e_a + e_b - EXP_BIAS.
  - Clear accumulator; counter = ITER-1; go to MULT.
- FSM MULT:
  - Each cycle, add (multiplier low BITS_PER_CYCLE bits x multiplicand) << (step*BITS_PER_CYCLE) into the 22-bit accumulator; shift the multiplier right by BITS_PER_CYCLE.
  - With BITS_PER_CYCLE=2, the partial product (0..3 x multiplicand) is formed by add/shift, not by a generic multiplier.
  - When counter==0, go to DONE; otherwise decrement the counter.
- FSM DONE:
  - out_valid=1; outputs held stable until out_ready.
  - On out_valid & out_ready, return to IDLE.
  - in_ready rises the cycle after the handshake, so there is no same-cycle accept.
- Latency:
  - Accept edge to out_valid = ITER+1 cycles (12 for BITS_PER_CYCLE=1, 7 for 2).
  - Minimum issue interval is ITER+2 cycles.
- in_valid while busy: ignored, not dropped. The producer holds it until in_ready.
- out_ready asserted while out_valid=0: no effect.
- Exponent: output = e_sum[4:0], wrapping mod 32. No saturation, because the downstream stage has no overflow detection.
- mantissa_prod range: 0..0x3FF001. Bit 21 or bit 20 is the leading one when both hidden bits are 1.

Optional Feature:
- Macro: MUL_EXC_FLAG_EN.
- Defined:
  - Adds outputs exp_ovf (1) and exp_udf (1), registered with the result and reset to 0.
  - exp_ovf = e_sum >= 31; exp_udf = e_sum < 0.
  - Both valid only while out_valid=1.
- Undefined: ports absent; the exponent simply wraps.

Decomposition:
- Shared package fp16_pkg holds:
  - constants FP16_EXP_W=5, FP16_FRAC_W=10, FP16_SIG_W=11, FP16_PROD_W=22, FP16_BIAS=15;
  - the FSM state enum {IDLE, MULT, DONE}.
- One natural sub-module: mul_pp_step, a combinational partial-product select/shift/add for one iteration. Everything else stays in the top module.

Test Plan:
- 0x3C00 x 0x3C00 (1.0 x 1.0) -> sign=0, exponent=0x0F, mantissa_prod=0x100000; out_valid exactly 12 cycles after accept (BITS_PER_CYCLE=1).
- 0x3E00 x 0x3E00 (1.5 x 1.5) -> exponent=0x0F, mantissa_prod=0x240000 (bit21 set); repeat with BITS_PER_CYCLE=2 and check latency 7 and the same result.
- 0x4000 x 0xC200 (2.0 x -3.0) with out_ready held low 5 cycles -> sign=1, exponent=0x11, mantissa_prod=0x180000 held stable; in_ready=0 throughout; in_ready=1 the cycle after the handshake.
- 0x7800 x 0x7800 -> exponent=0x0D (45 wraps), exp_ovf=1; 0x0400 x 0x0400 -> exponent=0x13 (-13 wraps), exp_udf=1 (with MUL_EXC_FLAG_EN).
- 0x0000 x 0x3C00 -> mantissa_prod=0, exponent=0x00, no flags.
- rst pulsed 4 cycles into MULT -> no out_valid, all outputs 0, in_ready=1 the cycle after rst deasserts; next op 0x3C00 x 0x3C00 is correct.

Source files
------------

// File: rtl/fp16_pkg.sv
// fp16_pkg: FP16 field widths, bias and the iterative multiplier FSM states.
package fp16_pkg;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_FRAC_W = 10;
  localparam int FP16_SIG_W  = 11;
  localparam int FP16_PROD_W = 22;
  localparam int FP16_BIAS   = 15;
  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
endpackage

// File: rtl/mul_pp_step.sv
// mul_pp_step: one shift-add iteration, adds 0..3 x the aligned multiplicand into the accumulator.
module mul_pp_step
  import fp16_pkg::*;
(
  input  logic [FP16_PROD_W-1:0] acc,
  input  logic [FP16_PROD_W-1:0] mcand,
  input  logic [1:0]             bits,
  output logic [FP16_PROD_W-1:0] sum
);
  always_comb sum = acc + (bits[0] ? mcand : '0) + (bits[1] ? {mcand[FP16_PROD_W-2:0], 1'b0} : '0);
endmodule

// File: rtl/mul_iter_mantissa.sv
// mul_iter_mantissa: iterative FP16 significand multiply with exponent sum and sign.
// Optional MUL_EXC_FLAG_EN adds exp_ovf/exp_udf outputs registered with the result.
module mul_iter_mantissa
  import fp16_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int EXP_BIAS       = FP16_BIAS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            op_a,
  input  logic [15:0]            op_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sign,
  output logic [FP16_EXP_W-1:0]  exponent,
  output logic [FP16_PROD_W-1:0] mantissa_prod
`ifdef MUL_EXC_FLAG_EN
  ,
  output logic                   exp_ovf,
  output logic                   exp_udf
`endif
);
  localparam int ITER = (BITS_PER_CYCLE == 2) ? 6 : 11;
`ifdef MUL_EXC_FLAG_EN
  localparam int ESW = 7;
`else
  localparam int ESW = 5;
`endif
  state_t state;
  logic [FP16_PROD_W-1:0] mcand, acc, acc_next;
  logic [FP16_SIG_W-1:0]  mplier;
  logic [3:0]             cnt;
  logic [ESW-1:0]         e_sum;
  logic                   s_r;
  logic [1:0]             bits;
  always_comb bits = (BITS_PER_CYCLE == 2) ? mplier[1:0] : {1'b0, mplier[0]};
  mul_pp_step u_step (.acc(acc), .mcand(mcand), .bits(bits), .sum(acc_next));
  // multiplicand is pre-shifted each step so its alignment tracks step*BITS_PER_CYCLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      sign          <= 1'b0;
      exponent      <= '0;
      mantissa_prod <= '0;
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
      cnt           <= '0;
      e_sum         <= '0;
      s_r           <= 1'b0;
`ifdef MUL_EXC_FLAG_EN
      exp_ovf       <= 1'b0;
      exp_udf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          mcand    <= {11'b0, |op_a[14:10], op_a[9:0]};
          mplier   <= {|op_b[14:10], op_b[9:0]};
          s_r      <= op_a[15] ^ op_b[15];
          e_sum    <= ESW'({2'b0, op_a[14:10]} + {2'b0, op_b[14:10]} - 7'(EXP_BIAS));
          acc      <= '0;
          cnt      <= 4'(ITER - 1);
          in_ready <= 1'b0;
          state    <= MULT;
        end
        MULT: begin
          acc    <= acc_next;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          if (cnt == 4'd0) begin
            state         <= DONE;
            out_valid     <= 1'b1;
            mantissa_prod <= acc_next;
            exponent      <= e_sum[4:0];
            sign          <= s_r;
`ifdef MUL_EXC_FLAG_EN
            exp_ovf       <= $signed(e_sum) >= 7'sd31;
            exp_udf       <= e_sum[6];
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_iter_mantissa.sv
// tb_mul_iter_mantissa: directed vectors run on a 1-bit and a 2-bit-per-cycle instance side by side.
module tb_mul_iter_mantissa;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [4:0]  e;
    logic [21:0] p;
    logic        ovf;
    logic        udf;
    int          hold;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] op_a = '0, op_b = '0;
  logic in_ready1, out_valid1, s1, fo1, fu1;
  logic in_ready2, out_valid2, s2, fo2, fu2;
  logic [4:0]  e1, e2;
  logic [21:0] p1, p2;
  int checks = 0, errors = 0;
  vec_t vecs [11];
  always #5 clk = ~clk;
  mul_iter_mantissa #(.BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid1), .out_ready(out_ready), .sign(s1), .exponent(e1), .mantissa_prod(p1)
`ifdef MUL_EXC_FLAG_EN
    , .exp_ovf(fo1), .exp_udf(fu1)
`endif
  );
  mul_iter_mantissa #(.BITS_PER_CYCLE(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid2), .out_ready(out_ready), .sign(s2), .exponent(e2), .mantissa_prod(p2)
`ifdef MUL_EXC_FLAG_EN
    , .exp_ovf(fo2), .exp_udf(fu2)
`endif
  );
`ifndef MUL_EXC_FLAG_EN
  assign fo1 = 1'b0;
  assign fu1 = 1'b0;
  assign fo2 = 1'b0;
  assign fu2 = 1'b0;
`endif
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic check_res(input string tag, input logic s, input logic [4:0] e, input logic [21:0] p,
                           input logic fo, input logic fu, input vec_t v);
    chk({tag, "_sign"}, 32'(s), 32'(v.s));
    chk({tag, "_exponent"}, 32'(e), 32'(v.e));
    chk({tag, "_mantissa"}, 32'(p), 32'(v.p));
`ifdef MUL_EXC_FLAG_EN
    chk({tag, "_exp_ovf"}, 32'(fo), 32'(v.ovf));
    chk({tag, "_exp_udf"}, 32'(fu), 32'(v.udf));
`endif
  endtask
  task automatic run_vec(input vec_t v);
    int n, l1, l2;
    chk("pre_in_ready1", 32'(in_ready1), 1);
    chk("pre_in_ready2", 32'(in_ready2), 1);
    op_a = v.a;
    op_b = v.b;
    in_valid = 1'b1;
    out_ready = (v.hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = 16'hFFFF;
    op_b = 16'hFFFF;
    l1 = 0;
    l2 = 0;
    n = 1;
    while ((l1 == 0 || l2 == 0) && n < 40) begin
      if (l1 == 0) begin
        if (out_valid1) begin
          l1 = n;
          check_res("u1", s1, e1, p1, fo1, fu1, v);
        end else chk("busy_in_ready1", 32'(in_ready1), 0);
      end
      if (l2 == 0) begin
        if (out_valid2) begin
          l2 = n;
          check_res("u2", s2, e2, p2, fo2, fu2, v);
        end else chk("busy_in_ready2", 32'(in_ready2), 0);
      end
      if (l1 == 0 || l2 == 0) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("latency1", 32'(l1), 12);
    chk("latency2", 32'(l2), 7);
    if (v.hold > 0) begin
      repeat (v.hold) begin
        @(posedge clk); #1;
        chk("hold_valid1", 32'(out_valid1), 1);
        chk("hold_in_ready1", 32'(in_ready1), 0);
        chk("hold_in_ready2", 32'(in_ready2), 0);
        check_res("hold_u1", s1, e1, p1, fo1, fu1, v);
        check_res("hold_u2", s2, e2, p2, fo2, fu2, v);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_in_ready1", 32'(in_ready1), 1);
    chk("post_in_ready2", 32'(in_ready2), 1);
    chk("post_valid1", 32'(out_valid1), 0);
    chk("post_valid2", 32'(out_valid2), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int seen;
    vecs = '{
      '{16'h3C00, 16'h3C00, 1'b0, 5'h0F, 22'h100000, 1'b0, 1'b0, 0},
      '{16'h3E00, 16'h3E00, 1'b0, 5'h0F, 22'h240000, 1'b0, 1'b0, 0},
      '{16'h4000, 16'hC200, 1'b1, 5'h11, 22'h180000, 1'b0, 1'b0, 5},
      '{16'h7800, 16'h7800, 1'b0, 5'h0D, 22'h100000, 1'b1, 1'b0, 0},
      '{16'h0400, 16'h0400, 1'b0, 5'h13, 22'h100000, 1'b0, 1'b1, 0},
      '{16'h0000, 16'h3C00, 1'b0, 5'h00, 22'h000000, 1'b0, 1'b0, 0},
      '{16'h7BFF, 16'h7BFF, 1'b0, 5'h0D, 22'h3FF001, 1'b1, 1'b0, 2},
      '{16'h4000, 16'h7800, 1'b0, 5'h1F, 22'h100000, 1'b1, 1'b0, 0},
      '{16'h3C00, 16'h7800, 1'b0, 5'h1E, 22'h100000, 1'b0, 1'b0, 0},
      '{16'h0200, 16'h3800, 1'b0, 5'h1F, 22'h080000, 1'b0, 1'b1, 0},
      '{16'h3C01, 16'hBC00, 1'b1, 5'h0F, 22'h100400, 1'b0, 1'b0, 0}
    };
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready1", 32'(in_ready1), 1);
    chk("rst_in_ready2", 32'(in_ready2), 1);
    chk("rst_valid1", 32'(out_valid1), 0);
    chk("rst_valid2", 32'(out_valid2), 0);
    chk("rst_out1", {9'b0, s1, e1, p1}, 0);
    chk("rst_out2", {9'b0, s2, e2, p2}, 0);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) run_vec(vecs[i]);
    op_a = 16'h3C00;
    op_b = 16'h3C00;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready1", 32'(in_ready1), 1);
    chk("abort_in_ready2", 32'(in_ready2), 1);
    chk("abort_out1", {8'b0, out_valid1, s1, e1, p1}, 0);
    chk("abort_out2", {8'b0, out_valid2, s2, e2, p2}, 0);
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid1 || out_valid2) seen++;
    end
    chk("abort_no_valid", 32'(seen), 0);
    run_vec(vecs[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
